// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: delays pixel/sync by L cycles and uses the look-ahead
// to insert the video preamble and leading guard band ahead of each active run.
module hdmi_period_scheduler #(
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int MIN_CTRL     = 12,
    parameter int DVI_MODE     = 0
) (
    input  logic        i_hdmi_clk,
    input  logic        i_reset_n,
    input  logic        i_display_enable,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [23:0] i_rgb,
    output logic [1:0]  o_period,
    output logic [1:0]  o_ctrl0,
    output logic [1:0]  o_ctrl1,
    output logic [1:0]  o_ctrl2,
    output logic [23:0] o_rgb,
    output logic        o_display_enable,
    output logic        o_timing_err
);

    localparam int L       = PREAMBLE_LEN + GUARD_LEN + 1;
    localparam int GAP_MIN = MIN_CTRL + GUARD_LEN;
    localparam int CNT_W   = $clog2(GAP_MIN + 1);

    typedef enum logic [1:0] {
        S_CTRL     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_GUARD    = 2'd2,
        S_VIDEO    = 2'd3
    } state_t;

    logic [L-1:0]     r_de_p;
    logic [L-1:0]     r_hs_p;
    logic [L-1:0]     r_vs_p;
    logic [L-1:0]     r_err_p;
    logic [23:0]      r_rgb_p [L];
    logic [CNT_W-1:0] r_gap_cnt;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_guard_win;
    logic             w_pre_win;
    logic             w_rise_in;
    logic             w_gap_short;

    logic             r_de_out;
    logic             r_err_out;
    logic [1:0]       r_ctrl0;
    logic [1:0]       r_ctrl1;
    logic [23:0]      r_rgb_out;

    assign w_rise_in   = i_display_enable & ~r_de_p[0];
    assign w_gap_short = (DVI_MODE == 0) && (r_gap_cnt < CNT_W'(GAP_MIN));

    // Input stage: delay line and blanking-gap counter.
    // The gap counter is held at zero during a run, so after a fall it counts
    // the low cycles of the gap; it leaves reset saturated so the first run is legal.
    always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_de_p    <= '0;
            r_hs_p    <= '0;
            r_vs_p    <= '0;
            r_err_p   <= '0;
            r_gap_cnt <= CNT_W'(GAP_MIN);
            for (int i = 0; i < L; i++) begin
                r_rgb_p[i] <= '0;
            end
        end else begin
            r_de_p     <= {r_de_p[L-2:0], i_display_enable};
            r_hs_p     <= {r_hs_p[L-2:0], i_hsync};
            r_vs_p     <= {r_vs_p[L-2:0], i_vsync};
            r_err_p    <= {r_err_p[L-2:0], w_rise_in & w_gap_short};
            r_rgb_p[0] <= i_rgb;
            for (int i = 1; i < L; i++) begin
                r_rgb_p[i] <= r_rgb_p[i-1];
            end
            if (i_display_enable) begin
                r_gap_cnt <= '0;
            end else if (r_gap_cnt != CNT_W'(GAP_MIN)) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    // Look-ahead decode: a rise that is d cycles old sits between taps d-1 and d.
    // Delayed DE wins over any window, which truncates an overlapping preamble.
    always_comb begin
        w_guard_win = 1'b0;
        w_pre_win   = 1'b0;
        for (int d = 1; d < L; d++) begin
            if (r_de_p[d-1] && !r_de_p[d]) begin
                if (d > PREAMBLE_LEN) begin
                    w_guard_win = 1'b1;
                end else begin
                    w_pre_win = 1'b1;
                end
            end
        end

        w_state_nxt = S_CTRL;
        if (r_de_p[L-1]) begin
            w_state_nxt = S_VIDEO;
        end else if ((DVI_MODE == 0) && w_guard_win) begin
            w_state_nxt = S_GUARD;
        end else if ((DVI_MODE == 0) && w_pre_win) begin
            w_state_nxt = S_PREAMBLE;
        end
    end

    always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_CTRL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output stage: every encoder-facing signal is registered.
    always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_de_out  <= 1'b0;
            r_err_out <= 1'b0;
            r_ctrl0   <= 2'b00;
            r_ctrl1   <= 2'b00;
            r_rgb_out <= '0;
        end else begin
            r_de_out  <= r_de_p[L-1];
            r_err_out <= r_err_p[L-1];
            r_ctrl0   <= {r_vs_p[L-1], r_hs_p[L-1]};
            r_ctrl1   <= (w_state_nxt == S_PREAMBLE) ? 2'b01 : 2'b00;
            r_rgb_out <= (w_state_nxt == S_VIDEO) ? r_rgb_p[L-1] : '0;
        end
    end

    assign o_period         = r_state;
    assign o_ctrl0          = r_ctrl0;
    assign o_ctrl1          = r_ctrl1;
    assign o_ctrl2          = 2'b00;
    assign o_rgb            = r_rgb_out;
    assign o_display_enable = r_de_out;
    assign o_timing_err     = r_err_out;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: HDMI and DVI instances share one stimulus
// stream and are checked every cycle against an event-painting reference model.
module tb_hdmi_period_scheduler;

    localparam int P       = 8;
    localparam int G       = 2;
    localparam int L       = P + G + 1;
    localparam int GAP_MIN = 14;
    localparam int N       = 12000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        de    = 1'b0;
    logic        hs    = 1'b0;
    logic        vs    = 1'b0;
    logic [23:0] rgb   = '0;

    logic [1:0]  per0, c00, c01, c02, per1, c10, c11, c12;
    logic [23:0] rgb0, rgb1;
    logic        de0, err0, de1, err1;

    int checks = 0;
    int errors = 0;
    int n      = 0;
    int base   = 0;

    bit          de_h   [N];
    logic [1:0]  sync_h [N];
    logic [23:0] rgb_h  [N];
    bit          pre_m  [N+L+1];
    bit          grd_m  [N+L+1];
    bit          err_m  [N+L+1];
    logic [1:0]  cap_per0 [N];
    logic [1:0]  cap_per1 [N];
    logic [1:0]  cap_c01  [N];
    logic        cap_err0 [N];

    always #5 clk = ~clk;

    hdmi_period_scheduler #(.PREAMBLE_LEN(P), .GUARD_LEN(G), .MIN_CTRL(12), .DVI_MODE(0)) u_hdmi (
        .i_hdmi_clk(clk), .i_reset_n(rst_n), .i_display_enable(de), .i_hsync(hs), .i_vsync(vs),
        .i_rgb(rgb), .o_period(per0), .o_ctrl0(c00), .o_ctrl1(c01), .o_ctrl2(c02),
        .o_rgb(rgb0), .o_display_enable(de0), .o_timing_err(err0)
    );

    hdmi_period_scheduler #(.PREAMBLE_LEN(P), .GUARD_LEN(G), .MIN_CTRL(12), .DVI_MODE(1)) u_dvi (
        .i_hdmi_clk(clk), .i_reset_n(rst_n), .i_display_enable(de), .i_hsync(hs), .i_vsync(vs),
        .i_rgb(rgb), .o_period(per1), .o_ctrl0(c10), .o_ctrl1(c11), .o_ctrl2(c12),
        .o_rgb(rgb1), .o_display_enable(de1), .o_timing_err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic bit get_de(input int i);
        if (i < base) return 1'b0;
        return de_h[i];
    endfunction

    // A sampled rise paints its preamble/guard windows and, if the gap before
    // it was short, an error at the edge its video starts.
    task automatic record(input int k);
        int g;
        int i;
        de_h[k]   = de;
        sync_h[k] = {vs, hs};
        rgb_h[k]  = rgb;
        if (de && !get_de(k-1)) begin
            for (int j = 1; j <= P; j++) pre_m[k+j] = 1'b1;
            for (int j = P+1; j < L; j++) grd_m[k+j] = 1'b1;
            g = 0;
            i = k - 1;
            while (i >= base && !de_h[i] && g < GAP_MIN) begin
                g++;
                i--;
            end
            if (i < base) g = GAP_MIN;
            err_m[k+L] = (g < GAP_MIN);
        end
    endtask

    task automatic check_edge(input int e);
        bit          d0;
        logic [1:0]  sy;
        logic [23:0] rg;
        int          ph;
        bit          ee;
        d0 = 1'b0; sy = 2'b00; rg = '0; ph = 0; ee = 1'b0;
        if (rst_n) begin
            d0 = get_de(e-L);
            if (e - L >= base) begin
                sy = sync_h[e-L];
                rg = rgb_h[e-L];
            end
            ph = d0 ? 3 : grd_m[e] ? 2 : pre_m[e] ? 1 : 0;
            ee = err_m[e];
        end
        chk("hdmi_period", per0, ph);
        chk("hdmi_ctrl0", c00, sy);
        chk("hdmi_ctrl1", c01, (ph == 1) ? 1 : 0);
        chk("hdmi_ctrl2", c02, 0);
        chk("hdmi_rgb", rgb0, d0 ? rg : 24'h0);
        chk("hdmi_de", de0, d0);
        chk("hdmi_err", err0, ee);
        chk("dvi_period", per1, d0 ? 3 : 0);
        chk("dvi_ctrl0", c10, sy);
        chk("dvi_ctrl1", c11, 0);
        chk("dvi_ctrl2", c12, 0);
        chk("dvi_rgb", rgb1, d0 ? rg : 24'h0);
        chk("dvi_de", de1, d0);
        chk("dvi_err", err1, 0);
        cap_per0[e] = per0;
        cap_per1[e] = per1;
        cap_c01[e]  = c01;
        cap_err0[e] = err0;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) record(n);
        #1;
        check_edge(n);
        n++;
    endtask

    task automatic drive(input bit d, input logic [23:0] pix);
        de  = d;
        hs  = 1'($urandom);
        vs  = 1'($urandom);
        rgb = pix;
        step();
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        base  = n;
        for (int i = n; i <= n + L; i++) begin
            pre_m[i] = 1'b0;
            grd_m[i] = 1'b0;
            err_m[i] = 1'b0;
        end
    endtask

    task automatic run_pair(input int gap, input int exp_pre, input int exp_err);
        int s, npre, ngrd, nerr;
        s = n;
        repeat (20)  drive(1'b0, 24'($urandom));
        repeat (4)   drive(1'b1, 24'($urandom));
        repeat (gap) drive(1'b0, 24'($urandom));
        repeat (4)   drive(1'b1, 24'($urandom));
        repeat (24)  drive(1'b0, 24'($urandom));
        npre = 0; ngrd = 0; nerr = 0;
        for (int e = s; e < n; e++) begin
            if (cap_per0[e] == 2'd1) npre++;
            if (cap_per0[e] == 2'd2) ngrd++;
            if (cap_err0[e]) nerr++;
        end
        chk("pair_preamble_cycles", npre, exp_pre);
        chk("pair_guard_cycles", ngrd, 2 * G);
        chk("pair_err_pulses", nerr, exp_err);
        chk("pair_err_at_video", cap_err0[s + 24 + gap + L], exp_err);
        chk("pair_run2_video", cap_per0[s + 24 + gap + L], 3);
    endtask

    initial begin
        int b;
        int exp_p;
        int grun;
        logic [1:0] prev;

        // Reset held for a few edges: everything must read zero.
        rst_n = 1'b0;
        repeat (3) drive(1'b0, 24'($urandom));
        release_reset();

        // Scenario 1: DE low for 20 edges, then a 4-pixel run.
        b = n;
        for (int r = 0; r < 40; r++) begin
            if (r >= 20 && r < 24) drive(1'b1, 24'h112233 + 24'(r));
            else drive(1'b0, 24'($urandom));
        end
        for (int r = 0; r < 40; r++) begin
            exp_p = (r >= 21 && r <= 28) ? 1 : (r >= 29 && r <= 30) ? 2 : (r >= 31 && r <= 34) ? 3 : 0;
            chk("sc1_period", cap_per0[b+r], exp_p);
            chk("sc1_ctrl1", cap_c01[b+r], (exp_p == 1) ? 1 : 0);
            chk("sc1_dvi_period", cap_per1[b+r], (r >= 31 && r <= 34) ? 3 : 0);
            chk("sc1_err", cap_err0[b+r], 0);
        end

        // Gap scenarios: legal, one short, and short enough to truncate the preamble.
        run_pair(14, 16, 0);
        run_pair(13, 16, 1);
        run_pair(5, 11, 1);

        // Reset in the middle of a video run, released with DE still high.
        repeat (20) drive(1'b1, 24'($urandom));
        chk("rst_pre_video", per0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_period", per0, 0);
        chk("rst_async_rgb", rgb0, 0);
        chk("rst_async_de", de0, 0);
        chk("rst_async_ctrl0", c00, 0);
        chk("rst_async_dvi_period", per1, 0);
        repeat (3) drive(1'b1, 24'($urandom));
        release_reset();
        b = n;
        repeat (30) drive(1'b1, 24'($urandom));
        chk("rst_rel_first", cap_per0[b], 0);
        chk("rst_rel_preamble", cap_per0[b+1], 1);
        chk("rst_rel_guard", cap_per0[b+9], 2);
        chk("rst_rel_video", cap_per0[b+11], 3);
        chk("rst_rel_no_err", cap_err0[b+11], 0);

        // Random frames: gaps of at least GUARD_LEN keep every guard band whole.
        prev = per0;
        grun = 0;
        while (n < 10400) begin
            int lo, hi;
            lo = $urandom_range(2, 25);
            hi = $urandom_range(1, 20);
            for (int i = 0; i < lo + hi; i++) begin
                drive(i >= lo, 24'($urandom));
                if (per0 == 2'd3 && prev != 2'd3) begin
                    chk("rand_guard_before_video", grun, G);
                    grun = 0;
                end else if (per0 == 2'd2) begin
                    grun++;
                end else if (per0 != 2'd3) begin
                    grun = 0;
                end
                prev = per0;
            end
        end
        repeat (L + 2) drive(1'b0, 24'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
